// File: rtl/bcd_chain_counter.sv
// rtl/bcd_chain_counter.sv - Chained multi-decade BCD counter with terminal wrap, checked load and optional down count.
// Optional feature macro: BCD_CNT_DOWN_EN (enables dir-controlled decrement/borrow).
module bcd_chain_counter #(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] TERM   = (4*DIGITS)'(16'h9675)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   ld_val,
    input  logic                  ena,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   q,
    output logic                  wrap,
    output logic                  err
);
    localparam int W = 4 * DIGITS;

    function automatic logic all_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_chain_counter: DIGITS out of range 1..8");
        end
        if (!all_bcd(TERM)) begin : g_bad_term
            $error("bcd_chain_counter: TERM contains a non-BCD nibble");
        end
    endgenerate

    logic [W-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    logic [W-1:0] inc_v;
    logic         inc_carry;

    // Ripple carry: each decade rolls 9->0 and passes the carry upward.
    always_comb begin
        inc_v     = q_q;
        inc_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (q_q[4*i +: 4] == 4'd9) begin
                    inc_v[4*i +: 4] = 4'd0;
                end else begin
                    inc_v[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                    inc_carry       = 1'b0;
                end
            end
        end
    end

`ifdef BCD_CNT_DOWN_EN
    logic [W-1:0] dec_v;
    logic         dec_borrow;

    always_comb begin
        dec_v      = q_q;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_borrow) begin
                if (q_q[4*i +: 4] == 4'd0) begin
                    dec_v[4*i +: 4] = 4'd9;
                end else begin
                    dec_v[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                    dec_borrow      = 1'b0;
                end
            end
        end
    end
`else
    logic unused_dir;
    assign unused_dir = dir;
`endif

    // With all nibbles <= 9, the packed compare equals the decimal magnitude compare.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            if (all_bcd(ld_val) && (ld_val <= TERM)) begin
                q_d = ld_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (ena) begin
`ifdef BCD_CNT_DOWN_EN
            if (dir) begin
                if (q_q == '0) begin
                    q_d    = TERM;
                    wrap_d = 1'b1;
                end else begin
                    q_d = dec_v;
                end
            end else
`endif
            if (q_q == TERM) begin
                q_d    = '0;
                wrap_d = 1'b1;
            end else begin
                q_d = inc_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;
endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-digit BCD counter with a programmable terminal value, the successor to the single-digit decade counter in the display-counter datapath. It chains DIGITS decade stages with internal ripple carry/borrow, counts 0 to TERM (default 9675) and wraps. It supports synchronous clear, parallel load with legality check, and an optional down-count mode. It drives the 7-segment digit decoders directly with packed BCD.

## Interface
- DIGITS, 4: number of BCD decades. Legal range is 1..8.
- TERM, 16'h9675: terminal count as packed BCD, width 4*DIGITS. Every nibble must be ≤9; an illegal nibble is an elaboration error.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- clr  in  1  synchronous clear to 0.
- ld  in  1  synchronous parallel load request.
- ld_val  in  4*DIGITS  packed BCD value to load.
- ena  in  1  count enable, one step per cycle.
- dir  in  1  0 = up, 1 = down. Only honoured when BCD_CNT_DOWN_EN is defined.
- q  out  4*DIGITS  packed BCD count; nibble 0 is the least significant decade.
- wrap  out  1  one-cycle pulse; q has just wrapped.
- err  out  1  one-cycle pulse; the last ld was rejected.

## Operation
- All outputs are registered. Reset (rst_n=0), asynchronous: q=0, wrap=0, err=0, taking effect without a clock edge and held while low.
- Per-edge priority: clr > ld > ena. Lower-priority requests in the same cycle are ignored.
- clr: q←0; wrap=0; err=0.
- ld: ld_val is legal if every nibble is ≤9 and ld_val ≤ TERM (BCD magnitude compare).
  - Legal: q←ld_val, err=0.
  - Illegal: q unchanged, err=1.
  - wrap=0 in both cases.
- ena, up:
  - q==TERM: q←0 and wrap=1.
  - Otherwise BCD increment. Digit 9 becomes 0 and carries into the next decade; a carry out of the top decade cannot occur below TERM.
- ena, down (macro defined, dir=1):
  - q==0: q←TERM and wrap=1.
  - Otherwise BCD decrement. Digit 0 becomes 9 and borrows from the next decade.
- No request: q holds; wrap=0; err=0.
- q is never outside 0..TERM and never holds a non-BCD nibble.
- Counts are valid decimal values, not binary. Arithmetic is per-nibble BCD with no binary intermediate wider than 4 bits plus carry.
- Reference design point: TERM=16'h9675 gives the 0000..9675 modulus, i.e. 9676 states.

## Timing
- Latency is 1 cycle. A request sampled at edge N is visible on q after edge N.
- wrap asserts in the same cycle q shows the wrapped value (0 up, TERM down) and deasserts the next cycle unless another wrap occurs.
- err asserts the cycle after the illegal ld edge, for one cycle.
- Back-to-back ena gives one step per cycle, including across a wrap (TERM→0→1 on consecutive edges).
- rst_n deassertion is synchronised externally. The first count edge is the first rising clk with rst_n=1.
- Reset mid-operation aborts any pending ld/clr; no wrap or err is generated.
- dir changes take effect on the next enabled edge; no dead cycle.

## Configuration
- BCD_CNT_DOWN_EN defined: dir selects direction as above, and decrement/borrow logic is compiled in.
- BCD_CNT_DOWN_EN undefined: decrement logic is absent. The dir port remains for a stable interface but is ignored, so the block counts up only.

## Test plan
- Async reset: q=16'h0123, drive rst_n=0 between clock edges → q=0, wrap=0, err=0 immediately. q stays 0 while ena=1 and rst_n=0.
- Up wrap: ld 16'h9674, then ena=1 for 3 cycles → q=16'h9675/wrap=0, then 16'h0000/wrap=1, then 16'h0001/wrap=0.
- BCD ripple: ld 16'h0999, ena=1 → q=16'h1000. ld 16'h0009, ena → 16'h0010. No value ever shows a nibble >9.
- Down (macro defined): ld 16'h1000, dir=1, ena → 16'h0999. From q=0, ena → 16'h9675 with wrap=1. Without the macro, the same stimulus gives 16'h1001.
- Illegal load: q=16'h0042, ld 16'h9676 → q=16'h0042, err=1 one cycle. ld 16'h12A4 → err=1, q unchanged. ld 16'h9675 → q=16'h9675, err=0.
- Priority: clr=1, ld=1 (16'h0500), ena=1 with q=16'h0300 → q=0. Then ld=1, ena=1 (16'h0500) → q=16'h0500, not 16'h0501.
